// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-queue FSM states and instruction/PC constants.
package riscv_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} ifq_state_t;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO with flush; power-of-two depth so pointers wrap naturally.
module inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch with in-order memory requests and a {pc, inst} queue.
// Define IFETCH_MISALIGN_TRAP_EN to add a sticky misalign_err that halts fetch on misaligned redirects.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifq_state_t state, state_n;
  logic [31:0] fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] outstanding, outstanding_n, drop_cnt, drop_cnt_n, count;
  logic req_fire, push, pop, halt;
  logic [63:0] head;
  assign redir_pc = redirect_pc & ~32'h3;
`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) misalign_err <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
  end
  assign halt = misalign_err;
`else
  assign halt = 1'b0;
`endif
  // count+outstanding bounds every push, so the queue can never overflow
  assign imem_req_valid = state != BOOT && !halt && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_valid     = count != '0;
  assign push           = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign instruction    = inst_valid ? head[31:0] : INST_NOP;
  assign inst_pc        = inst_valid ? head[63:32] : RESET_PC;
  always_comb begin
    outstanding_n = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_n    = redirect_valid ? outstanding_n : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
    state_n       = redirect_valid ? FLUSH :
                    state == BOOT ? RUN :
                    (state == FLUSH && drop_cnt_n == '0) ? RUN : state;
  end
  // rsp_pc follows the surviving request stream: redirect restarts it, each push advances it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
      fetch_pc    <= redirect_valid ? redir_pc : req_fire ? fetch_pc + PC_STEP : fetch_pc;
      rsp_pc      <= redirect_valid ? redir_pc : push ? rsp_pc + PC_STEP : rsp_pc;
    end
  end
  inst_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({rsp_pc, imem_rsp_data}),
    .rdata (head),
    .count (count)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed fetch scenarios with an in-order latency memory model and PC scoreboard.
module tb_ifetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic inst_valid, inst_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instruction, inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_err;
`endif
  ifetch_queue #(.RESET_PC(32'h100), .DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .misalign_err   (misalign_err),
`endif
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );
  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int req_cnt = 0;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // memory: accepts every request while ready, answers in order after lat cycles
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat - 1});
        req_cnt++;
      end
      imem_rsp_valid <= 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_data  <= mdata(mq[0].addr);
        imem_rsp_valid <= 1'b1;
        void'(mq.pop_front());
      end
    end
  end
  // scoreboard: accepted request addresses are the expected delivery order; redirect/reset discard them
  always @(negedge clk) begin
    if (!rstn || redirect_valid) exp_q.delete();
    else begin
      if (imem_req_valid && imem_req_ready) exp_q.push_back(imem_req_addr);
      if (inst_valid && inst_ready) begin
        automatic logic [31:0] e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEE0;
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", instruction, mdata(e));
        got.push_back(inst_pc);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask
  task automatic wait_got(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, rb, k;
    rstn = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(2);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_instruction", instruction, 32'h13);
    chk("rst_inst_pc", inst_pc, 32'h100);
    rstn = 1'b1; inst_ready = 1'b1;
    g0 = got.size();
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    step(1);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    step(1);
    chk("latency_not_yet", 32'(inst_valid), 32'd0);
    step(1);
    chk("latency_visible", 32'(inst_valid), 32'd1);
    chk("latency_pc", inst_pc, 32'h100);
    wait_got("seq_timeout", g0 + 3, 20);
    chk("seq0", got[g0], 32'h100);
    chk("seq1", got[g0+1], 32'h104);
    chk("seq2", got[g0+2], 32'h108);
    inst_ready = 1'b0;
    do_reset();
    rb = req_cnt;
    step(20);
    chk("full_req_cnt", 32'(req_cnt - rb), 32'd4);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", inst_pc, 32'h100);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    step(5);
    chk("after_pop_req_cnt", 32'(req_cnt - rb), 32'd5);
    chk("after_pop_req_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1; lat = 5;
    do_reset();
    rb = req_cnt; k = 0;
    while (req_cnt - rb < 3 && k < 20) begin step(1); k++; end
    chk("inflight3", 32'(req_cnt - rb), 32'd3);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    g0 = got.size();
    step(1);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("redir_addr", imem_req_addr, 32'h200);
    wait_got("redir_timeout", g0 + 2, 60);
    chk("redir_first", got[g0], 32'h200);
    chk("redir_second", got[g0+1], 32'h204);
    lat = 1;
    step(10);
    chk("pre_redir_inst_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    g0 = got.size();
    step(1);
    redirect_valid = 1'b0;
    wait_got("simul_timeout", g0 + 2, 30);
    chk("simul_first", got[g0], 32'h400);
    chk("simul_second", got[g0+1], 32'h404);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    g0 = got.size();
    step(1);
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
    wait_got("wrap_timeout", g0 + 2, 30);
    chk("wrap_first", got[g0], 32'hFFFF_FFFC);
    chk("wrap_second", got[g0+1], 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_clear", 32'(misalign_err), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    step(1);
    redirect_valid = 1'b0;
    chk("mis_set", 32'(misalign_err), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
      step(1);
    end
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    do_reset();
    chk("mis_reset", 32'(misalign_err), 32'd0);
    step(1);
    chk("mis_resume", 32'(imem_req_valid), 32'd1);
`else
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    g0 = got.size();
    step(1);
    redirect_valid = 1'b0;
    chk("align_addr", imem_req_addr, 32'h200);
    wait_got("align_timeout", g0 + 1, 30);
    chk("align_first", got[g0], 32'h200);
`endif
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
